// File: rtl/aes256_uart_ctrl_if.sv
// Byte-link and AES-core signal bundle for the frame sequencer; the master side is the controller.
interface aes256_uart_ctrl_if #(
    parameter int KEY_BYTES  = 32,
    parameter int TEXT_BYTES = 16
);
    logic [7:0]              rx_data;
    logic                    rx_new_data;
    logic [8*KEY_BYTES-1:0]  aes_key;
    logic [8*TEXT_BYTES-1:0] aes_text;
    logic                    aes_start;
    logic                    aes_done;
    logic [8*TEXT_BYTES-1:0] aes_result;
    logic [7:0]              tx_data;
    logic                    tx_new_data;
    logic                    tx_busy;
    logic                    busy;
    logic                    rx_drop;
    logic                    err_timeout;
    logic                    clr_flags;

    modport master (
        input  rx_data, rx_new_data, aes_done, aes_result, tx_busy, clr_flags,
        output aes_key, aes_text, aes_start, tx_data, tx_new_data, busy, rx_drop, err_timeout
    );

    modport slave (
        output rx_data, rx_new_data, aes_done, aes_result, tx_busy, clr_flags,
        input  aes_key, aes_text, aes_start, tx_data, tx_new_data, busy, rx_drop, err_timeout
    );
endinterface

// File: rtl/aes256_uart_ctrl.sv
// Collects a key+plaintext frame from UART RX, runs one AES-256 encryption, streams the ciphertext to UART TX.
// Last RX byte -> aes_start 1 clk; aes_done -> first tx strobe 2 clk; TX paced by tx_busy, RX bytes outside RECV dropped.
module aes256_uart_ctrl #(
    parameter int KEY_BYTES   = 32,
    parameter int TEXT_BYTES  = 16,
    parameter int RX_TIMEOUT  = 174000,
    parameter int AES_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    aes256_uart_ctrl_if.master  bus
);
    localparam int FRAME = KEY_BYTES + TEXT_BYTES;
    localparam int GAP_W = $clog2(RX_TIMEOUT + 1);
    localparam int WD_W  = $clog2(AES_TIMEOUT + 1);
    localparam int KI_W  = $clog2(KEY_BYTES);
    localparam int TI_W  = $clog2(TEXT_BYTES);

    typedef enum logic [2:0] {
        RECV, START, WAIT_AES, SEND, TX_ACK, TX_DRAIN
    } state_t;

    state_t                          state_q, state_d;
    logic [5:0]                      cnt_q, cnt_d;
    logic [4:0]                      idx_q, idx_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [WD_W-1:0]                 wd_q, wd_d;
    logic [KEY_BYTES-1:0][7:0]       key_q, key_d;
    logic [TEXT_BYTES-1:0][7:0]      text_q, text_d;
    logic [TEXT_BYTES-1:0][7:0]      resp_q, resp_d;
    logic [7:0]                      tx_data_q, tx_data_d;
    logic                            tx_new_q, tx_new_d;
    logic                            rx_drop_q, rx_drop_d;
    logic                            err_q, err_d;
    logic                            set_err;
    logic                            set_drop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        wd_d      = wd_q;
        key_d     = key_q;
        text_d    = text_q;
        resp_d    = resp_q;
        tx_data_d = tx_data_q;
        tx_new_d  = 1'b0;
        set_err   = 1'b0;
        set_drop  = bus.rx_new_data && (state_q != RECV);

        case (state_q)
            RECV: begin
                if (bus.rx_new_data) begin
                    if (cnt_q < 6'(KEY_BYTES))
                        key_d[KI_W'(cnt_q)] = bus.rx_data;
                    else
                        text_d[TI_W'(cnt_q - 6'(KEY_BYTES))] = bus.rx_data;
                    cnt_d = cnt_q + 6'd1;
                    gap_d = '0;
                    if (cnt_q == 6'(FRAME - 1))
                        state_d = START;
                end else if (cnt_q != 6'd0) begin
                    // Partial frame abandoned: counter rewinds, stored bytes get overwritten later.
                    if (gap_q >= GAP_W'(RX_TIMEOUT - 1)) begin
                        cnt_d   = '0;
                        gap_d   = '0;
                        set_err = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT_AES;
            end
            WAIT_AES: begin
                if (bus.aes_done) begin
                    resp_d  = bus.aes_result;
                    idx_d   = '0;
                    state_d = SEND;
                end else if (wd_q >= WD_W'(AES_TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    cnt_d   = '0;
                    state_d = RECV;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    tx_data_d = resp_q[TI_W'(idx_q)];
                    tx_new_d  = 1'b1;
                    state_d   = TX_ACK;
                end
            end
            TX_ACK: begin
                if (bus.tx_busy)
                    state_d = TX_DRAIN;
            end
            TX_DRAIN: begin
                if (!bus.tx_busy) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'(TEXT_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = RECV;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = RECV;
        endcase

        // A set event in the same cycle as clr_flags keeps the flag high.
        rx_drop_d = (rx_drop_q && !bus.clr_flags) || set_drop;
        err_d     = (err_q && !bus.clr_flags) || set_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RECV;
            cnt_q     <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            wd_q      <= '0;
            key_q     <= '0;
            text_q    <= '0;
            resp_q    <= '0;
            tx_data_q <= '0;
            tx_new_q  <= 1'b0;
            rx_drop_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            key_q     <= key_d;
            text_q    <= text_d;
            resp_q    <= resp_d;
            tx_data_q <= tx_data_d;
            tx_new_q  <= tx_new_d;
            rx_drop_q <= rx_drop_d;
            err_q     <= err_d;
        end
    end

    assign bus.aes_key     = key_q;
    assign bus.aes_text    = text_q;
    assign bus.aes_start   = (state_q == START);
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_new_data = tx_new_q;
    assign bus.busy        = (state_q != RECV);
    assign bus.rx_drop     = rx_drop_q;
    assign bus.err_timeout = err_q;
endmodule
